// File: rtl/hs_cmd_queue_if.sv
`default_nettype none
// ============================================================================
// hs_cmd_queue_if : host command / link command bundle for hs_cmd_queue
// Revision 1.0
// ============================================================================
interface hs_cmd_queue_if #(
    parameter int C_SLOTS  = 32,
    parameter int C_DWORDS = 16
);
    localparam int C_ID_W = $clog2(C_SLOTS);
    localparam int C_DA_W = $clog2(C_DWORDS);

    logic              PhyReset;
    logic              PhyReady;
    logic              CmdReq;
    logic              CmdAck;
    logic              CmdErr;
    logic [C_ID_W-1:0] CmdId;
    logic [31:0]       Cmd;
    logic [C_DA_W-1:0] CmdAddr;
    logic              CmdWr;
    logic              CmdDone;
    logic [C_ID_W-1:0] CmdDoneId;
    logic              cmd_req;
    logic [C_ID_W-1:0] cmd_slot;
    logic              cmd_done;
    logic [C_DA_W-1:0] cmd_raddr;
    logic [31:0]       cmd_rdata;

    modport slave (
        input  PhyReset, CmdReq, CmdId, Cmd, CmdAddr, CmdWr, cmd_done, cmd_raddr,
        output PhyReady, CmdAck, CmdErr, CmdDone, CmdDoneId, cmd_req, cmd_slot, cmd_rdata
    );

    modport master (
        output PhyReset, CmdReq, CmdId, Cmd, CmdAddr, CmdWr, cmd_done, cmd_raddr,
        input  PhyReady, CmdAck, CmdErr, CmdDone, CmdDoneId, cmd_req, cmd_slot, cmd_rdata
    );
endinterface
`default_nettype wire

// File: rtl/hs_cmd_queue.sv
`default_nettype none
// ============================================================================
// hs_cmd_queue : slot memory, pending bitmap and in-order issue FIFO to a link
// Revision 1.0
// ============================================================================
module hs_cmd_queue #(
    parameter int C_SLOTS   = 32,
    parameter int C_DWORDS  = 16,
    parameter int C_PHY_DLY = 4
) (
    input  wire logic     sys_clk,
    input  wire logic     sys_rst,
    hs_cmd_queue_if.slave bus
);
    localparam int                C_ID_W    = $clog2(C_SLOTS);
    localparam int                C_DA_W    = $clog2(C_DWORDS);
    localparam logic [3:0]        C_DLY     = 4'(C_PHY_DLY);
    localparam logic [C_ID_W-1:0] C_PTR_ONE = 1;
    localparam logic [C_ID_W:0]   C_CNT_ONE = 1;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_REQ = 1'b1} state_t;

    logic [31:0]       r_mem  [C_SLOTS*C_DWORDS];
    logic [C_ID_W-1:0] r_fifo [C_SLOTS];
    logic [C_ID_W-1:0] r_wr_ptr;
    logic [C_ID_W-1:0] r_rd_ptr;
    logic [C_ID_W:0]   r_count;
    logic [C_SLOTS-1:0] r_pending;
    logic              r_ack;
    logic              r_err;
    logic              r_done;
    logic [C_ID_W-1:0] r_done_id;
    logic [31:0]       r_rdata;
    logic              r_phy_ready;
    logic [3:0]        r_phy_cnt;
    state_t            r_state;
    state_t            w_state_nxt;

    logic               w_accept;
    logic               w_link_up;
    logic               w_slot_busy;
    logic               w_cmd_err;
    logic               w_wr_ok;
    logic               w_push;
    logic               w_pop;
    logic [C_ID_W-1:0]  w_head;
    logic [C_SLOTS-1:0] w_pending_nxt;
    logic [C_ID_W:0]    w_count_nxt;

    // An issue arriving in the same cycle PhyReset asserts would be flushed, so it is rejected.
    assign w_accept    = bus.CmdReq && !r_ack;
    assign w_link_up   = r_phy_ready && !bus.PhyReset;
    assign w_slot_busy = r_pending[bus.CmdId];
    assign w_cmd_err   = w_slot_busy || (!bus.CmdWr && !w_link_up);
    assign w_wr_ok     = w_accept && bus.CmdWr && !w_slot_busy;
    assign w_push      = w_accept && !bus.CmdWr && !w_slot_busy && w_link_up;
    assign w_pop       = (r_state == ST_REQ) && bus.cmd_done && !bus.PhyReset;
    assign w_head      = r_fifo[r_rd_ptr];

    always_comb begin
        w_pending_nxt = r_pending;
        if (w_pop) begin
            w_pending_nxt[w_head] = 1'b0;
        end
        if (w_push) begin
            w_pending_nxt[bus.CmdId] = 1'b1;
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + C_CNT_ONE;
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - C_CNT_ONE;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (r_count != '0 && w_link_up) w_state_nxt = ST_REQ;
            ST_REQ:  if (bus.cmd_done)               w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (bus.PhyReset) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Slot memory and FIFO storage are deliberately left out of reset.
    always_ff @(posedge sys_clk) begin
        if (w_wr_ok) begin
            r_mem[{bus.CmdId, bus.CmdAddr}] <= bus.Cmd;
        end
        if (w_push) begin
            r_fifo[r_wr_ptr] <= bus.CmdId;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_done      <= 1'b0;
            r_done_id   <= '0;
            r_rdata     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_pending   <= '0;
            r_phy_ready <= 1'b0;
            r_phy_cnt   <= C_DLY;
        end else begin
            r_ack  <= w_accept;
            r_err  <= w_accept && w_cmd_err;
            r_done <= w_pop;
            if (w_pop) begin
                r_done_id <= w_head;
            end
            if (r_count != '0) begin
                r_rdata <= r_mem[{w_head, bus.cmd_raddr}];
            end
            if (bus.PhyReset) begin
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_count     <= '0;
                r_pending   <= '0;
                r_phy_ready <= 1'b0;
                r_phy_cnt   <= C_DLY;
            end else begin
                r_pending <= w_pending_nxt;
                r_count   <= w_count_nxt;
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
                end
                if (r_phy_cnt != 4'd0) begin
                    r_phy_cnt   <= r_phy_cnt - 4'd1;
                    r_phy_ready <= (r_phy_cnt == 4'd1);
                end
            end
        end
    end

    assign bus.CmdAck    = r_ack;
    assign bus.CmdErr    = r_err;
    assign bus.CmdDone   = r_done;
    assign bus.CmdDoneId = r_done_id;
    assign bus.PhyReady  = r_phy_ready;
    assign bus.cmd_req   = (r_state == ST_REQ);
    assign bus.cmd_slot  = (r_state == ST_REQ) ? w_head : '0;
    assign bus.cmd_rdata = r_rdata;
endmodule
`default_nettype wire

// File: tb/tb_hs_cmd_queue.sv
`default_nettype none
// ============================================================================
// tb_hs_cmd_queue : directed self-checking bench for hs_cmd_queue
// Revision 1.0
// ============================================================================
module tb_hs_cmd_queue;
    localparam int C_SLOTS   = 32;
    localparam int C_DWORDS  = 16;
    localparam int C_PHY_DLY = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   done_count = 0;

    hs_cmd_queue_if #(.C_SLOTS(C_SLOTS), .C_DWORDS(C_DWORDS)) bus ();

    hs_cmd_queue #(
        .C_SLOTS  (C_SLOTS),
        .C_DWORDS (C_DWORDS),
        .C_PHY_DLY(C_PHY_DLY)
    ) dut (
        .sys_clk(clk),
        .sys_rst(rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.CmdDone === 1'b1) done_count++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic host_cmd(input logic wr, input logic [4:0] id, input logic [3:0] addr,
                            input logic [31:0] data, output logic err);
        bit got;
        got = 1'b0;
        bus.CmdReq = 1'b1; bus.CmdWr = wr; bus.CmdId = id; bus.CmdAddr = addr; bus.Cmd = data;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            got = (bus.CmdAck === 1'b1);
        end
        bus.CmdReq = 1'b0;
        err = bus.CmdErr;
        if (!got) begin
            checks++; errors++;
            $display("FAIL host_ack_timeout: id %0d got no CmdAck, required CmdAck=1", id);
            err = 1'bx;
        end
    endtask

    task automatic wait_req();
        bit got;
        got = (bus.cmd_req === 1'b1);
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = (bus.cmd_req === 1'b1);
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL link_req_timeout: cmd_req stayed %b, required 1", bus.cmd_req);
        end
    endtask

    task automatic done_pulse();
        bus.cmd_done = 1'b1;
        @(negedge clk);
        bus.cmd_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.PhyReset = 1'b0; bus.CmdReq = 1'b0; bus.CmdWr = 1'b0; bus.CmdId = '0;
        bus.Cmd = '0; bus.CmdAddr = '0; bus.cmd_done = 1'b0; bus.cmd_raddr = '0;
        repeat (3) @(negedge clk);
        checks++; if ({bus.CmdAck, bus.CmdErr, bus.CmdDone, bus.cmd_req, bus.PhyReady} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b required 00000",
                {bus.CmdAck, bus.CmdErr, bus.CmdDone, bus.cmd_req, bus.PhyReady}); end
        checks++; if (bus.CmdDoneId !== 5'd0 || bus.cmd_slot !== 5'd0) begin
            errors++; $display("FAIL reset_ids: got %0d/%0d required 0/0", bus.CmdDoneId, bus.cmd_slot); end
        checks++; if (bus.cmd_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %h required 0", bus.cmd_rdata); end
        rst = 1'b0;
        for (int k = 1; k <= C_PHY_DLY; k++) begin
            @(negedge clk);
            checks++; if (bus.PhyReady !== (k == C_PHY_DLY)) begin
                errors++; $display("FAIL reset_phy_ready_c%0d: got %b required %b", k, bus.PhyReady, (k == C_PHY_DLY)); end
        end
    endtask

    task automatic test_write_issue();
        logic err;
        int   bad;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            host_cmd(1'b1, 5'd3, 4'(i), 32'h300 + 32'(i), err);
            if (err !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin
            errors++; $display("FAIL wr_slot3_err: got %0d rejected writes required 0", bad); end
        host_cmd(1'b0, 5'd3, 4'd0, 32'h0, err);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL issue3_err: got %b required 0", err); end
        wait_req();
        checks++; if (bus.cmd_slot !== 5'd3) begin
            errors++; $display("FAIL issue3_slot: got %0d required 3", bus.cmd_slot); end
        bus.cmd_raddr = 4'd5;
        @(negedge clk);
        checks++; if (bus.cmd_rdata !== 32'h305) begin
            errors++; $display("FAIL rdata_dw5: got %h required 305", bus.cmd_rdata); end
        bus.cmd_raddr = 4'd15;
        @(negedge clk);
        checks++; if (bus.cmd_rdata !== 32'h30f) begin
            errors++; $display("FAIL rdata_dw15: got %h required 30f", bus.cmd_rdata); end
        done_pulse();
        checks++; if (bus.CmdDone !== 1'b1 || bus.CmdDoneId !== 5'd3) begin
            errors++; $display("FAIL done3: got done=%b id=%0d required 1/3", bus.CmdDone, bus.CmdDoneId); end
    endtask

    task automatic test_order();
        logic err;
        int   base;
        host_cmd(1'b0, 5'd7, 4'd0, 32'h0, err);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL issue7_err: got %b required 0", err); end
        host_cmd(1'b0, 5'd2, 4'd0, 32'h0, err);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL issue2_err: got %b required 0", err); end
        wait_req();
        done_pulse();
        checks++; if (bus.CmdDone !== 1'b1 || bus.CmdDoneId !== 5'd7) begin
            errors++; $display("FAIL order_first: got done=%b id=%0d required 1/7", bus.CmdDone, bus.CmdDoneId); end
        wait_req();
        done_pulse();
        checks++; if (bus.CmdDone !== 1'b1 || bus.CmdDoneId !== 5'd2) begin
            errors++; $display("FAIL order_second: got done=%b id=%0d required 1/2", bus.CmdDone, bus.CmdDoneId); end
        repeat (2) @(negedge clk);
        checks++; if (bus.cmd_req !== 1'b0) begin
            errors++; $display("FAIL order_idle: cmd_req got %b required 0", bus.cmd_req); end
        base = done_count;
        done_pulse();
        @(negedge clk);
        checks++; if (done_count != base) begin
            errors++; $display("FAIL done_outside_req: got %0d CmdDone pulses required 0", done_count - base); end
    endtask

    task automatic test_duplicate();
        logic err;
        host_cmd(1'b1, 5'd4, 4'd0, 32'h4aa, err);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL dup_wr_ok: got %b required 0", err); end
        host_cmd(1'b0, 5'd4, 4'd0, 32'h0, err);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL dup_issue1: got %b required 0", err); end
        host_cmd(1'b0, 5'd4, 4'd0, 32'h0, err);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL dup_issue2: got %b required 1", err); end
        host_cmd(1'b1, 5'd4, 4'd0, 32'hdead, err);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL dup_wr_pending: got %b required 1", err); end
        wait_req();
        bus.cmd_raddr = 4'd0;
        @(negedge clk);
        checks++; if (bus.cmd_rdata !== 32'h4aa) begin
            errors++; $display("FAIL dup_mem_kept: got %h required 4aa", bus.cmd_rdata); end
        done_pulse();
        checks++; if (bus.CmdDone !== 1'b1 || bus.CmdDoneId !== 5'd4) begin
            errors++; $display("FAIL dup_done: got done=%b id=%0d required 1/4", bus.CmdDone, bus.CmdDoneId); end
        checks++; if (dut.r_count !== 6'd0) begin
            errors++; $display("FAIL dup_single_push: count got %0d required 0", dut.r_count); end
    endtask

    task automatic test_back_to_back();
        logic err;
        bus.CmdReq = 1'b1; bus.CmdWr = 1'b1; bus.CmdId = 5'd20; bus.CmdAddr = 4'd2; bus.Cmd = 32'haaaa_0002;
        @(negedge clk);
        checks++; if (bus.CmdAck !== 1'b1) begin errors++; $display("FAIL b2b_ack1: got %b required 1", bus.CmdAck); end
        bus.CmdAddr = 4'd3; bus.Cmd = 32'hbbbb_0003;
        @(negedge clk);
        checks++; if (bus.CmdAck !== 1'b0) begin errors++; $display("FAIL b2b_ack_gap: got %b required 0", bus.CmdAck); end
        @(negedge clk);
        checks++; if (bus.CmdAck !== 1'b1) begin errors++; $display("FAIL b2b_ack2: got %b required 1", bus.CmdAck); end
        bus.CmdReq = 1'b0;
        @(negedge clk);
        host_cmd(1'b0, 5'd20, 4'd0, 32'h0, err);
        wait_req();
        bus.cmd_raddr = 4'd2;
        @(negedge clk);
        checks++; if (bus.cmd_rdata !== 32'haaaa_0002) begin
            errors++; $display("FAIL b2b_dw2: got %h required aaaa0002", bus.cmd_rdata); end
        bus.cmd_raddr = 4'd3;
        @(negedge clk);
        checks++; if (bus.cmd_rdata !== 32'hbbbb_0003) begin
            errors++; $display("FAIL b2b_dw3: got %h required bbbb0003", bus.cmd_rdata); end
        done_pulse();
    endtask

    task automatic test_full();
        logic       err;
        logic [4:0] id;
        int         bad_err, bad_slot, bad_done;
        bad_err = 0; bad_slot = 0; bad_done = 0;
        for (int i = 0; i < C_SLOTS; i++) begin
            id = 5'((i * 5 + 3) % C_SLOTS);
            host_cmd(1'b0, id, 4'd0, 32'h0, err);
            if (err !== 1'b0) bad_err++;
        end
        checks++; if (bad_err != 0) begin errors++; $display("FAIL full_issue_err: got %0d rejects required 0", bad_err); end
        checks++; if (dut.r_count !== 6'd32) begin errors++; $display("FAIL full_count: got %0d required 32", dut.r_count); end
        for (int i = 0; i < C_SLOTS; i++) begin
            id = 5'((i * 5 + 3) % C_SLOTS);
            wait_req();
            if (bus.cmd_slot !== id) bad_slot++;
            done_pulse();
            if (bus.CmdDone !== 1'b1 || bus.CmdDoneId !== id) bad_done++;
        end
        checks++; if (bad_slot != 0) begin errors++; $display("FAIL full_slot_order: got %0d wrong heads required 0", bad_slot); end
        checks++; if (bad_done != 0) begin errors++; $display("FAIL full_done_order: got %0d wrong ids required 0", bad_done); end
        repeat (2) @(negedge clk);
        checks++; if (bus.cmd_req !== 1'b0 || dut.r_count !== 6'd0) begin
            errors++; $display("FAIL full_drained: got req=%b count=%0d required 0/0", bus.cmd_req, dut.r_count); end
    endtask

    task automatic test_phy_reset();
        logic err;
        int   base;
        for (int i = 0; i < 3; i++) begin
            host_cmd(1'b0, 5'(10 + i), 4'd0, 32'h0, err);
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL phy_issue%0d: got %b required 0", 10 + i, err); end
        end
        wait_req();
        base = done_count;
        bus.PhyReset = 1'b1; bus.cmd_done = 1'b1;
        @(negedge clk);
        bus.cmd_done = 1'b0;
        checks++; if (bus.cmd_req !== 1'b0 || bus.PhyReady !== 1'b0) begin
            errors++; $display("FAIL phy_flush: got req=%b ready=%b required 0/0", bus.cmd_req, bus.PhyReady); end
        host_cmd(1'b0, 5'd14, 4'd0, 32'h0, err);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL phy_issue_not_ready: got %b required 1", err); end
        host_cmd(1'b1, 5'd13, 4'd1, 32'hc0de_0013, err);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL phy_write_not_ready: got %b required 0", err); end
        bus.PhyReset = 1'b0;
        for (int k = 1; k <= C_PHY_DLY; k++) begin
            @(negedge clk);
            checks++; if (bus.PhyReady !== (k == C_PHY_DLY)) begin
                errors++; $display("FAIL phy_ready_c%0d: got %b required %b", k, bus.PhyReady, (k == C_PHY_DLY)); end
        end
        @(negedge clk);
        checks++; if (done_count != base || bus.cmd_req !== 1'b0) begin
            errors++; $display("FAIL phy_no_done: got %0d pulses req=%b required 0/0", done_count - base, bus.cmd_req); end
        host_cmd(1'b0, 5'd13, 4'd0, 32'h0, err);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL phy_reissue: got %b required 0", err); end
        wait_req();
        bus.cmd_raddr = 4'd1;
        @(negedge clk);
        checks++; if (bus.cmd_slot !== 5'd13 || bus.cmd_rdata !== 32'hc0de_0013) begin
            errors++; $display("FAIL phy_slot13: got slot=%0d data=%h required 13/c0de0013", bus.cmd_slot, bus.cmd_rdata); end
        done_pulse();
    endtask

    task automatic test_concurrent();
        logic err;
        host_cmd(1'b0, 5'd1, 4'd0, 32'h0, err);
        wait_req();
        bus.CmdReq = 1'b1; bus.CmdWr = 1'b0; bus.CmdId = 5'd9; bus.cmd_done = 1'b1;
        @(negedge clk);
        bus.CmdReq = 1'b0; bus.cmd_done = 1'b0;
        checks++; if (bus.CmdAck !== 1'b1 || bus.CmdErr !== 1'b0) begin
            errors++; $display("FAIL conc_ack9: got ack=%b err=%b required 1/0", bus.CmdAck, bus.CmdErr); end
        checks++; if (bus.CmdDone !== 1'b1 || bus.CmdDoneId !== 5'd1 || dut.r_count !== 6'd1) begin
            errors++; $display("FAIL conc_done1: got done=%b id=%0d count=%0d required 1/1/1",
                bus.CmdDone, bus.CmdDoneId, dut.r_count); end
        wait_req();
        checks++; if (bus.cmd_slot !== 5'd9) begin errors++; $display("FAIL conc_next9: got %0d required 9", bus.cmd_slot); end
        bus.CmdReq = 1'b1; bus.CmdWr = 1'b0; bus.CmdId = 5'd9; bus.cmd_done = 1'b1;
        @(negedge clk);
        bus.CmdReq = 1'b0; bus.cmd_done = 1'b0;
        checks++; if (bus.CmdAck !== 1'b1 || bus.CmdErr !== 1'b1) begin
            errors++; $display("FAIL conc_reissue9: got ack=%b err=%b required 1/1", bus.CmdAck, bus.CmdErr); end
        checks++; if (bus.CmdDoneId !== 5'd9 || dut.r_count !== 6'd0) begin
            errors++; $display("FAIL conc_done9: got id=%0d count=%0d required 9/0", bus.CmdDoneId, dut.r_count); end
        repeat (2) @(negedge clk);
        checks++; if (bus.cmd_req !== 1'b0) begin errors++; $display("FAIL conc_idle: got %b required 0", bus.cmd_req); end
    endtask

    initial begin
        test_reset();
        test_write_issue();
        test_order();
        test_duplicate();
        test_back_to_back();
        test_full();
        test_phy_reset();
        test_concurrent();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
